ami_wdma: RTL and testbench

//  Write-DMA engine driving the user AW/W/B channels of the AXI master interface in the usr_clk domain.

---
 rtl/ami_wdma.sv | 215 +++++++++++++++++++++
 tb/tb_ami_wdma.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_wdma.sv
// Write-DMA engine: splits one {addr,len} command into 4KB-safe INCR bursts
// on usr_aw*, streams s_* onto usr_w* with WLAST, collects B, reports done.
// Ports: usr_clk/usr_reset; cmd_*; s_*; usr_aw*/usr_w*/usr_b*; busy, done_*.
// Optional build macro AMI_WDMA_PERF_EN adds perf_cycles[31:0] (RUN cycles).
module ami_wdma #(
  parameter int AXI_DW   = 128,
  parameter int AXI_AW   = 40,
  parameter int AXI_IW   = 8,
  parameter int AXI_LW   = 8,
  parameter int DMA_LW   = 20,
  parameter int MAX_BLEN = 16,
  parameter int DMA_OD   = 4,
  parameter int DMA_ID   = 0
) (
  input  logic                usr_clk,
  input  logic                usr_reset,
  input  logic [AXI_AW-1:0]   cmd_addr,
  input  logic [DMA_LW-1:0]   cmd_len,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [AXI_DW-1:0]   s_data,
  input  logic [AXI_DW/8-1:0] s_strb,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [AXI_IW-1:0]   usr_awid,
  output logic [AXI_AW-1:0]   usr_awaddr,
  output logic [AXI_LW-1:0]   usr_awlen,
  output logic [2:0]          usr_awsize,
  output logic [1:0]          usr_awburst,
  output logic                usr_awvalid,
  input  logic                usr_awready,
  output logic [AXI_DW-1:0]   usr_wdata,
  output logic [AXI_DW/8-1:0] usr_wstrb,
  output logic                usr_wlast,
  output logic                usr_wvalid,
  input  logic                usr_wready,
  input  logic [AXI_IW-1:0]   usr_bid,
  input  logic [1:0]          usr_bresp,
  input  logic                usr_bvalid,
  output logic                usr_bready,
  output logic                busy,
  output logic                done_valid,
`ifdef AMI_WDMA_PERF_EN
  output logic [31:0]         perf_cycles,
`endif
  output logic                done_err
);

  localparam int BSH = $clog2(AXI_DW / 8);
  localparam int PW  = (DMA_OD > 1) ? $clog2(DMA_OD) : 1;
  localparam int OW  = $clog2(DMA_OD + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [AXI_AW-1:0] addr_q, awaddr_q, src_addr, next_addr;
  logic [DMA_LW-1:0] rem_q, src_rem, next_rem;
  logic [AXI_LW-1:0] awlen_q, wbeat, head;
  logic [AXI_LW-1:0] fifo_mem [DMA_OD];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [OW-1:0]     fifo_cnt, out_cnt, fifo_nx, out_nx;
  logic [12:0]       room;
  logic [31:0]       beats;
  logic              awvalid_q, err_q;
  logic              accept, aw_hs, w_hs, b_hs, pop;
  logic              fifo_ne, issue_ok, load_aw;
  logic              unused_ok;

  assign unused_ok = ^{usr_bid, cmd_addr[BSH-1:0]};

  assign accept  = cmd_valid & cmd_ready;
  assign aw_hs   = awvalid_q & usr_awready;
  assign fifo_ne = (fifo_cnt != '0);
  assign head    = fifo_mem[rd_ptr];
  assign w_hs    = usr_wvalid & usr_wready;
  assign pop     = w_hs & usr_wlast;
  // B is only meaningful while bursts are outstanding in RUN.
  assign b_hs    = usr_bvalid & (state == RUN) & (out_cnt != '0);

  // In IDLE the first burst is sized straight from the command so AW
  // can rise the cycle after accept.
  always_comb begin
    src_addr = addr_q;
    src_rem  = rem_q;
    if (state == IDLE) begin
      src_addr = {cmd_addr[AXI_AW-1:BSH], BSH'(0)};
      src_rem  = cmd_len;
    end
    room  = 13'h1000 - {1'b0, src_addr[11:0]};
    beats = 32'(src_rem);
    if (beats > 32'(MAX_BLEN))
      beats = 32'(MAX_BLEN);
    if (beats > 32'(room >> BSH))
      beats = 32'(room >> BSH);
    next_addr = src_addr + AXI_AW'(beats << BSH);
    next_rem  = src_rem - DMA_LW'(beats);
  end

  // Limits are checked against next-cycle occupancy so a returning B
  // or a popped burst frees a slot immediately.
  assign out_nx   = out_cnt + OW'(aw_hs) - OW'(b_hs);
  assign fifo_nx  = fifo_cnt + OW'(aw_hs) - OW'(pop);
  assign issue_ok = (out_nx < OW'(DMA_OD)) &
                    (fifo_nx < OW'(DMA_OD)) &
                    (src_rem != '0);

  always_comb begin
    load_aw = 1'b0;
    unique case (state)
      IDLE:    load_aw = accept & issue_ok;
      RUN:     load_aw = (~awvalid_q | aw_hs) & issue_ok;
      default: load_aw = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = (cmd_len != '0) ? RUN : DONE;
      RUN:
        if (rem_q == '0 && !awvalid_q &&
            fifo_cnt == '0 && out_cnt == '0)
          state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q <= src_addr;
        rem_q  <= cmd_len;
        err_q  <= 1'b0;
      end
      if (load_aw) begin
        awvalid_q <= 1'b1;
        awaddr_q  <= src_addr;
        awlen_q   <= AXI_LW'(beats - 32'd1);
        addr_q    <= next_addr;
        rem_q     <= next_rem;
      end else if (aw_hs) begin
        awvalid_q <= 1'b0;
      end
      if (b_hs && usr_bresp != 2'b00)
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      out_cnt  <= '0;
      wbeat    <= '0;
    end else begin
      fifo_cnt <= fifo_nx;
      out_cnt  <= out_nx;
      if (aw_hs)
        wr_ptr <= (wr_ptr == PW'(DMA_OD - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DMA_OD - 1)) ? '0 : rd_ptr + 1'b1;
      if (w_hs)
        wbeat <= usr_wlast ? '0 : wbeat + 1'b1;
    end
  end

  always_ff @(posedge usr_clk) begin
    if (aw_hs)
      fifo_mem[wr_ptr] <= awlen_q;
  end

`ifdef AMI_WDMA_PERF_EN
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset)
      perf_cycles <= '0;
    else if (accept)
      perf_cycles <= '0;
    else if (state == RUN && perf_cycles != 32'hFFFF_FFFF)
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif

  assign cmd_ready   = (state == IDLE) & ~usr_reset;
  assign busy        = (state != IDLE);
  assign done_valid  = (state == DONE);
  assign done_err    = done_valid & err_q;

  assign usr_awid    = AXI_IW'(DMA_ID);
  assign usr_awaddr  = awaddr_q;
  assign usr_awlen   = awlen_q;
  assign usr_awsize  = 3'(BSH);
  assign usr_awburst = 2'b01;
  assign usr_awvalid = awvalid_q;

  assign usr_wdata   = s_data;
  assign usr_wstrb   = s_strb;
  assign usr_wvalid  = s_valid & fifo_ne;
  assign usr_wlast   = fifo_ne & (wbeat == head);
  assign s_ready     = usr_wready & fifo_ne;
  assign usr_bready  = 1'b1;

endmodule

// File: tb/tb_ami_wdma.sv
// Directed bench for ami_wdma: burst split, 4KB split, len 0,
// outstanding limit, error reporting, reset mid-command.
module tb_ami_wdma;

  logic         clk = 1'b0;
  logic         usr_reset;
  logic [39:0]  cmd_addr;
  logic [19:0]  cmd_len;
  logic         cmd_valid, cmd_ready;
  logic [127:0] s_data;
  logic [15:0]  s_strb;
  logic         s_valid, s_ready;
  logic [7:0]   usr_awid, usr_awlen;
  logic [39:0]  usr_awaddr;
  logic [2:0]   usr_awsize;
  logic [1:0]   usr_awburst;
  logic         usr_awvalid, usr_awready;
  logic [127:0] usr_wdata;
  logic [15:0]  usr_wstrb;
  logic         usr_wlast, usr_wvalid, usr_wready;
  logic [7:0]   usr_bid;
  logic [1:0]   usr_bresp;
  logic         usr_bvalid, usr_bready;
  logic         busy, done_valid, done_err;
`ifdef AMI_WDMA_PERF_EN
  logic [31:0]  perf_cycles;
`endif

  ami_wdma dut (
    .usr_clk(clk), .usr_reset(usr_reset),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_data(s_data), .s_strb(s_strb),
    .s_valid(s_valid), .s_ready(s_ready),
    .usr_awid(usr_awid), .usr_awaddr(usr_awaddr),
    .usr_awlen(usr_awlen), .usr_awsize(usr_awsize),
    .usr_awburst(usr_awburst), .usr_awvalid(usr_awvalid),
    .usr_awready(usr_awready),
    .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
    .usr_wlast(usr_wlast), .usr_wvalid(usr_wvalid),
    .usr_wready(usr_wready),
    .usr_bid(usr_bid), .usr_bresp(usr_bresp),
    .usr_bvalid(usr_bvalid), .usr_bready(usr_bready),
    .busy(busy), .done_valid(done_valid),
`ifdef AMI_WDMA_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .done_err(done_err)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0, acc = 0, bcyc = 0;
  int w_cnt, allowed, pend = 0, b_cnt, done_cnt, done_cyc;
  int err_b = 0;
  bit b_en = 1, rnd = 0;
  bit done_err_s, lead_err, data_err, attr_err, stable_err;
  bit hold_v;
  logic [39:0] hold_a;
  logic [7:0]  hold_l;
  logic [39:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  int          aw_cyc_q[$];
  int          last_q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers change away from the active edge.
  always @(negedge clk) begin
    usr_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    usr_wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    s_data = {$urandom, $urandom, $urandom, $urandom};
    s_strb = 16'($urandom);
    usr_bvalid = b_en && pend > 0 && !usr_reset;
    usr_bresp  = (b_cnt + 1 == err_b) ? 2'b10 : 2'b00;
  end

  always @(posedge clk) begin
    cyc++;
    if (usr_reset) begin
      pend = 0;
      hold_v = 0;
    end else begin
      if (usr_wvalid && usr_wready) begin
        w_cnt++;
        if (w_cnt > allowed) lead_err = 1;
        if (usr_wdata !== s_data || usr_wstrb !== s_strb)
          data_err = 1;
        if (usr_wlast) last_q.push_back(w_cnt);
      end
      if (hold_v && (!usr_awvalid || usr_awaddr !== hold_a ||
                     usr_awlen !== hold_l))
        stable_err = 1;
      hold_v = usr_awvalid && !usr_awready;
      hold_a = usr_awaddr;
      hold_l = usr_awlen;
      if (usr_awvalid && usr_awready) begin
        aw_addr_q.push_back(usr_awaddr);
        aw_len_q.push_back(usr_awlen);
        aw_cyc_q.push_back(cyc);
        allowed += int'(usr_awlen) + 1;
        pend++;
        if (usr_awsize !== 3'd4 || usr_awburst !== 2'b01 ||
            usr_awid !== 8'd0)
          attr_err = 1;
      end
      if (usr_bvalid && usr_bready) begin
        pend--;
        b_cnt++;
      end
      if (done_valid) begin
        done_cnt++;
        done_cyc = cyc;
        done_err_s = done_err;
      end
    end
  end

  task automatic clear_logs();
    aw_addr_q.delete(); aw_len_q.delete();
    aw_cyc_q.delete(); last_q.delete();
    w_cnt = 0; allowed = 0; b_cnt = 0; done_cnt = 0;
    lead_err = 0; data_err = 0; attr_err = 0; stable_err = 0;
  endtask

  task automatic start_cmd(input logic [39:0] a, input logic [19:0] l);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    clear_logs();
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1;
    acc = cyc + 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({tag, " done count"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, " w leads aw"}, 64'(lead_err), 64'd0);
    chk({tag, " w data"}, 64'(data_err), 64'd0);
    chk({tag, " aw attrs"}, 64'(attr_err), 64'd0);
    chk({tag, " aw stable"}, 64'(stable_err), 64'd0);
  endtask

  initial begin
    usr_reset = 1; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
    s_valid = 1; usr_bid = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst awvalid", 64'(usr_awvalid), 64'd0);
    chk("rst wvalid", 64'(usr_wvalid), 64'd0);
    chk("rst s_ready", 64'(s_ready), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'({done_valid, done_err}), 64'd0);
    usr_reset = 0;
    @(negedge clk);
    chk("idle cmd_ready", 64'(cmd_ready), 64'd1);
    chk("bready", 64'(usr_bready), 64'd1);

    // 32 beats at 0x1000: two 16-beat bursts
    start_cmd(40'h1000, 20'd32);
    chk("t1 busy", 64'(busy), 64'd1);
    wait_done("t1", 300);
    chk("t1 aw count", 64'(aw_addr_q.size()), 64'd2);
    chk("t1 aw0 addr", 64'(aw_addr_q[0]), 64'h1000);
    chk("t1 aw0 len", 64'(aw_len_q[0]), 64'd15);
    chk("t1 aw1 addr", 64'(aw_addr_q[1]), 64'h1100);
    chk("t1 aw1 len", 64'(aw_len_q[1]), 64'd15);
    chk("t1 aw0 cycle", 64'(aw_cyc_q[0]), 64'(acc + 1));
    chk("t1 w beats", 64'(w_cnt), 64'd32);
    chk("t1 last count", 64'(last_q.size()), 64'd2);
    chk("t1 last0", 64'(last_q[0]), 64'd16);
    chk("t1 last1", 64'(last_q[1]), 64'd32);
    chk("t1 done_err", 64'(done_err_s), 64'd0);
    chk("t1 idle busy", 64'(busy), 64'd0);
    chk_stream("t1");

    // 4KB split
    start_cmd(40'h0FC0, 20'd8);
    wait_done("t2", 300);
    chk("t2 aw count", 64'(aw_addr_q.size()), 64'd2);
    chk("t2 aw0 addr", 64'(aw_addr_q[0]), 64'h0FC0);
    chk("t2 aw0 len", 64'(aw_len_q[0]), 64'd3);
    chk("t2 aw1 addr", 64'(aw_addr_q[1]), 64'h1000);
    chk("t2 aw1 len", 64'(aw_len_q[1]), 64'd3);
    chk("t2 w beats", 64'(w_cnt), 64'd8);
    chk("t2 last0", 64'(last_q[0]), 64'd4);
    chk("t2 last1", 64'(last_q[1]), 64'd8);

    // unaligned low bits are dropped; single-beat burst
    start_cmd(40'h20_0000_2008, 20'd1);
    wait_done("t3", 300);
    chk("t3 aw count", 64'(aw_addr_q.size()), 64'd1);
    chk("t3 aw0 addr", 64'(aw_addr_q[0]), 64'h20_0000_2000);
    chk("t3 aw0 len", 64'(aw_len_q[0]), 64'd0);
    chk("t3 last0", 64'(last_q[0]), 64'd1);

    // zero length
    start_cmd(40'h3000, 20'd0);
    wait_done("t4", 50);
    chk("t4 aw count", 64'(aw_addr_q.size()), 64'd0);
    chk("t4 w beats", 64'(w_cnt), 64'd0);
    chk("t4 done latency", 64'(done_cyc - acc), 64'd1);
    chk("t4 done_err", 64'(done_err_s), 64'd0);

    // outstanding limit: 96 beats, B withheld
    b_en = 0;
    start_cmd(40'h0, 20'd96);
    repeat (90) @(negedge clk);
    chk("t5 aw held at 4", 64'(aw_addr_q.size()), 64'd4);
    chk("t5 w drained", 64'(w_cnt), 64'd64);
    @(posedge clk);
    #1;
    b_en = 1;
    bcyc = cyc + 1;
    wait_done("t5", 300);
    chk("t5 aw count", 64'(aw_addr_q.size()), 64'd6);
    chk("t5 aw4 addr", 64'(aw_addr_q[4]), 64'h400);
    chk("t5 aw4 cycle", 64'(aw_cyc_q[4]), 64'(bcyc + 1));
    chk("t5 w beats", 64'(w_cnt), 64'd96);
    chk("t5 done_err", 64'(done_err_s), 64'd0);

    // error response on second B, random backpressure
    rnd = 1;
    err_b = 2;
    start_cmd(40'h5000, 20'd32);
    wait_done("t6", 600);
    chk("t6 done_err", 64'(done_err_s), 64'd1);
    chk("t6 w beats", 64'(w_cnt), 64'd32);
    chk("t6 aw1 addr", 64'(aw_addr_q[1]), 64'h5100);
    chk_stream("t6");
    err_b = 0;
    start_cmd(40'h6000, 20'd40);
    wait_done("t7", 600);
    chk("t7 done_err", 64'(done_err_s), 64'd0);
    chk("t7 aw count", 64'(aw_addr_q.size()), 64'd3);
    chk("t7 aw2 len", 64'(aw_len_q[2]), 64'd7);
    chk("t7 last2", 64'(last_q[2]), 64'd40);
    chk_stream("t7");
    rnd = 0;

    // reset mid-command
    start_cmd(40'h0, 20'd64);
    begin
      int n = 0;
      while (aw_addr_q.size() == 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t8 first aw", 64'(aw_addr_q.size()), 64'd1);
    usr_reset = 1;
    #1;
    chk("t8 rst outs", 64'({usr_awvalid, usr_wvalid, s_ready,
                            busy, done_valid, done_err,
                            cmd_ready}), 64'd0);
    @(negedge clk);
    usr_reset = 0;
    @(negedge clk);
    chk("t8 cmd_ready", 64'(cmd_ready), 64'd1);
    start_cmd(40'h7000, 20'd16);
    wait_done("t8", 300);
    chk("t8 aw count", 64'(aw_addr_q.size()), 64'd1);
    chk("t8 aw0 addr", 64'(aw_addr_q[0]), 64'h7000);
    chk("t8 w beats", 64'(w_cnt), 64'd16);
    chk("t8 done_err", 64'(done_err_s), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
